// File: rtl/ccg_bist_pkg.sv
// Shared types and constants for the CCG netlist self-test harness:
// FSM states, LFSR taps, MISR polynomial and the default LFSR seed.
package ccg_bist_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int          LFSR_TAP_HI  = 20;
    localparam int          LFSR_TAP_LO  = 18;
    localparam logic [15:0] MISR_POLY    = 16'h1021;
    localparam logic [20:0] DEFAULT_SEED = 21'h000001;
    localparam int          MAX_SIG_W    = 32;

    // One MISR step of width w (w <= MAX_SIG_W): feedback is the top bit plus every
    // bit sitting below a polynomial tap, then the response is XORed in.
    function automatic logic [MAX_SIG_W-1:0] misr_next(
        input logic [MAX_SIG_W-1:0] s,
        input logic [MAX_SIG_W-1:0] d,
        input logic [MAX_SIG_W-1:0] poly,
        input int                   w
    );
        logic [MAX_SIG_W-1:0] mask;
        logic                 fb;
        mask = (w >= MAX_SIG_W) ? {MAX_SIG_W{1'b1}}
                                : ((MAX_SIG_W'(1) << w) - MAX_SIG_W'(1));
        fb   = ^(s & mask & ((poly >> 1) | (MAX_SIG_W'(1) << (w - 1))));
        return ({s[MAX_SIG_W-2:0], fb} & mask) ^ d;
    endfunction

endpackage

// File: rtl/ccg_bist_harness_if.sv
// Harness-to-controller bus: run control, golden signature, netlist response
// in one direction; stimulus, status and signature in the other.
interface ccg_bist_harness_if #(
    parameter int IN_W  = 21,
    parameter int OUT_W = 10,
    parameter int SIG_W = 16
);
    logic             start;
    logic [SIG_W-1:0] golden;
    logic [OUT_W-1:0] response_in;
    logic [IN_W-1:0]  pattern_out;
    logic             busy;
    logic             done;
    logic             pass;
    logic             fail;
    logic [SIG_W-1:0] signature;
    logic [20:0]      pat_count;

    modport master (
        output start, golden, response_in,
        input  pattern_out, busy, done, pass, fail, signature, pat_count
    );

    modport slave (
        input  start, golden, response_in,
        output pattern_out, busy, done, pass, fail, signature, pat_count
    );
endinterface

// File: rtl/ccg_misr.sv
// Multiple-input signature register compacting the netlist response vector.
module ccg_misr
    import ccg_bist_pkg::*;
#(
    parameter int SIG_W = 16,
    parameter int OUT_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    input  logic [OUT_W-1:0] data_in,
    output logic [SIG_W-1:0] sig
);
    logic [SIG_W-1:0] r_sig;
    logic [SIG_W-1:0] w_next;

    assign w_next = SIG_W'(misr_next(MAX_SIG_W'(r_sig), MAX_SIG_W'(data_in),
                                     MAX_SIG_W'(MISR_POLY), SIG_W));
    assign sig    = r_sig;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         r_sig <= '0;
        else if (clear)  r_sig <= '0;
        else if (enable) r_sig <= w_next;
    end
endmodule

// File: rtl/ccg_bist_harness.sv
// LFSR stimulus generator, MISR response compactor and run FSM for
// self-testing a 21-in / 10-out combinational CCG netlist.
module ccg_bist_harness
    import ccg_bist_pkg::*;
#(
    parameter int              IN_W         = 21,
    parameter int              OUT_W        = 10,
    parameter int              SIG_W        = 16,
    parameter int              NUM_PATTERNS = 1024,
    parameter logic [IN_W-1:0] SEED         = IN_W'(DEFAULT_SEED)
) (
    input logic               clk,
    input logic               rst,
    ccg_bist_harness_if.slave bus
);
    // An all-zero LFSR would lock up, so a zero seed is promoted to 1.
    localparam logic [IN_W-1:0] SEED_EFF = (SEED == '0) ? IN_W'(1) : SEED;
    localparam logic [20:0]     LAST     = 21'(NUM_PATTERNS);

    state_t           r_state;
    logic [IN_W-1:0]  r_pat;
    logic [20:0]      r_cnt;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;
    logic             r_fail;

    logic             w_lfsr_fb;
    logic [20:0]      w_cnt_next;
    logic             w_clear;
    logic             w_enable;
    logic [SIG_W-1:0] w_sig;
    logic [SIG_W-1:0] w_sig_next;

    assign w_lfsr_fb  = r_pat[LFSR_TAP_HI] ^ r_pat[LFSR_TAP_LO];
    assign w_cnt_next = r_cnt + 21'd1;
    assign w_enable   = (r_state == RUN);
    assign w_clear    = (r_state != RUN) && bus.start;

    // Post-absorb signature, so the verdict lands on the same edge as the last absorb.
    assign w_sig_next = SIG_W'(misr_next(MAX_SIG_W'(w_sig), MAX_SIG_W'(bus.response_in),
                                         MAX_SIG_W'(MISR_POLY), SIG_W));

    ccg_misr #(.SIG_W(SIG_W), .OUT_W(OUT_W)) u_misr (
        .clk     (clk),
        .rst     (rst),
        .clear   (w_clear),
        .enable  (w_enable),
        .data_in (bus.response_in),
        .sig     (w_sig)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_pat   <= SEED_EFF;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_fail  <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        r_state <= RUN;
                        r_pat   <= SEED_EFF;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                        r_pass  <= 1'b0;
                        r_fail  <= 1'b0;
                    end
                end
                RUN: begin
                    r_pat <= {r_pat[IN_W-2:0], w_lfsr_fb};
                    r_cnt <= w_cnt_next;
                    if (w_cnt_next == LAST) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= (w_sig_next == bus.golden);
                        r_fail  <= (w_sig_next != bus.golden);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_pass  <= 1'b0;
                    r_fail  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pattern_out = r_pat;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.pass        = r_pass;
    assign bus.fail        = r_fail;
    assign bus.signature   = w_sig;
    assign bus.pat_count   = r_cnt;
endmodule

// File: tb/tb_ccg_bist_harness.sv
// Bench for ccg_bist_harness: four harnesses (1, 2, 4 and 1024 patterns) checked
// every cycle against a run-level model, plus literal expectations from the test plan.
module tb_ccg_bist_harness;

    localparam int ND  = 4;
    localparam int BIG = 3;
    localparam int M_IDLE = 0, M_RUN = 1, M_DONE = 2;

    function automatic int np_of(input int g);
        case (g)
            0:       return 1;
            1:       return 2;
            2:       return 4;
            default: return 1024;
        endcase
    endfunction

    // Stand-in CCG netlist: arbitrary but fixed combinational mix of x0..x20.
    function automatic logic [9:0] netlist(input logic [20:0] x);
        logic [9:0] f;
        for (int i = 0; i < 10; i++)
            f[i] = x[i] ^ (x[i+10] & x[(i+3)%21]) ^ x[20-i];
        return f;
    endfunction

    function automatic logic [15:0] misr(input logic [15:0] s, input logic [9:0] d);
        return {s[14:0], s[15] ^ s[11] ^ s[4]} ^ {6'd0, d};
    endfunction

    function automatic logic [20:0] lfsr(input logic [20:0] p);
        return {p[19:0], p[20] ^ p[18]};
    endfunction

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst;
    logic [ND-1:0]  start;
    logic [15:0]    golden  [ND];
    logic [9:0]     resp_in [ND];
    logic [20:0]    act_pat [ND];
    logic [15:0]    act_sig [ND];
    logic [20:0]    act_cnt [ND];
    logic [ND-1:0]  act_busy, act_done, act_pass, act_fail;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        ccg_bist_harness_if #(.IN_W(21), .OUT_W(10), .SIG_W(16)) ifc ();
        ccg_bist_harness #(.NUM_PATTERNS(np_of(g))) dut (
            .clk (clk),
            .rst (rst),
            .bus (ifc)
        );
        assign ifc.start  = start[g];
        assign ifc.golden = golden[g];
        if (g == BIG) begin : g_net
            assign ifc.response_in = netlist(ifc.pattern_out);
        end else begin : g_const
            assign ifc.response_in = resp_in[g];
        end
        assign act_pat[g]  = ifc.pattern_out;
        assign act_sig[g]  = ifc.signature;
        assign act_cnt[g]  = ifc.pat_count;
        assign act_busy[g] = ifc.busy;
        assign act_done[g] = ifc.done;
        assign act_pass[g] = ifc.pass;
        assign act_fail[g] = ifc.fail;
    end

    // Model: run phase, patterns absorbed so far, running signature, verdict.
    logic [20:0] pat_seq [0:1024];
    int          m_mode  [ND];
    int          m_k     [ND];
    logic [15:0] m_sig   [ND];
    logic        m_pass  [ND];
    logic        m_fail  [ND];
    logic [15:0] exp_full;
    bit          armed = 1'b0;
    int          n_chk = 0;
    int          n_err = 0;

    task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s dut%0d: got %h expected %h at %0t", nm, g, act, exp, $time);
        end
    endtask

    task automatic model_reset(input int g);
        m_mode[g] = M_IDLE;
        m_k[g]    = 0;
        m_sig[g]  = '0;
        m_pass[g] = 1'b0;
        m_fail[g] = 1'b0;
    endtask

    task automatic model_edge();
        for (int g = 0; g < ND; g++) begin
            if (rst) begin
                model_reset(g);
            end else if (m_mode[g] != M_RUN) begin
                if (start[g]) begin
                    model_reset(g);
                    m_mode[g] = M_RUN;
                end
            end else begin
                m_sig[g] = misr(m_sig[g], (g == BIG) ? netlist(pat_seq[m_k[g]]) : resp_in[g]);
                m_k[g]++;
                if (m_k[g] == np_of(g)) begin
                    m_mode[g] = M_DONE;
                    m_pass[g] = (m_sig[g] == golden[g]);
                    m_fail[g] = (m_sig[g] != golden[g]);
                end
            end
        end
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        model_edge();
    end

    initial forever begin
        @(negedge clk);
        if (armed) begin
            for (int g = 0; g < ND; g++) begin
                chk("pattern_out", g, act_pat[g],  pat_seq[m_k[g]]);
                chk("signature",   g, act_sig[g],  m_sig[g]);
                chk("pat_count",   g, act_cnt[g],  m_k[g]);
                chk("busy",        g, act_busy[g], m_mode[g] == M_RUN);
                chk("done",        g, act_done[g], m_mode[g] == M_DONE);
                chk("pass",        g, act_pass[g], m_pass[g]);
                chk("fail",        g, act_fail[g], m_fail[g]);
            end
        end
    end

    task automatic pulse_start(input int g);
        start[g] = 1'b1;
        @(negedge clk);
        start[g] = 1'b0;
    endtask

    task automatic wait_done(input int g, input int budget);
        int n = 0;
        while (!act_done[g] && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("wait_done", g, act_done[g], 1);
    endtask

    task automatic wait_cnt(input int g, input logic [20:0] v, input int budget);
        int n = 0;
        while (act_cnt[g] != v && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("wait_cnt", g, act_cnt[g], v);
    endtask

    initial begin
        logic [20:0] lit;
        rst   = 1'b1;
        start = '0;
        for (int g = 0; g < ND; g++) begin
            golden[g]  = '0;
            resp_in[g] = '0;
            model_reset(g);
        end
        pat_seq[0] = 21'h000001;
        for (int k = 1; k <= 1024; k++) pat_seq[k] = lfsr(pat_seq[k-1]);
        exp_full = '0;
        for (int k = 0; k < 1024; k++) exp_full = misr(exp_full, netlist(pat_seq[k]));

        repeat (2) @(negedge clk);
        armed = 1'b1;
        chk("rst_pattern", BIG, act_pat[BIG], 21'h000001);
        chk("rst_sig",     BIG, act_sig[BIG], 16'h0000);
        chk("rst_cnt",     BIG, act_cnt[BIG], 0);
        chk("rst_flags",   BIG, {act_busy[BIG], act_done[BIG], act_pass[BIG], act_fail[BIG]}, 4'b0000);
        rst = 1'b0;
        @(negedge clk);

        // Sequence, zero response (NP=4) and constant response (NP=1, NP=2).
        golden[0] = 16'h0003; resp_in[0] = 10'h001;
        golden[1] = 16'h0003; resp_in[1] = 10'h001;
        golden[2] = 16'h0000; resp_in[2] = 10'h000;
        golden[3] = 16'h0000;
        start = '1;
        @(negedge clk);
        start = '0;
        for (int k = 0; k < 21; k++) begin
            lit = (k < 19) ? (21'h1 << k) : ((k == 19) ? 21'h080001 : 21'h100002);
            chk("lfsr_seq",  BIG, act_pat[BIG], lit);
            chk("seq_busy",  BIG, act_busy[BIG], 1);
            chk("np4_done",  2,   act_done[2], k >= 4);
            chk("np1_done",  0,   act_done[0], k >= 1);
            @(negedge clk);
        end
        chk("np1_sig",  0, act_sig[0], 16'h0001);
        chk("np1_fail", 0, {act_pass[0], act_fail[0]}, 2'b01);
        chk("np2_sig",  1, act_sig[1], 16'h0003);
        chk("np2_pass", 1, {act_pass[1], act_fail[1]}, 2'b10);
        chk("np4_sig",  2, act_sig[2], 16'h0000);
        chk("np4_cnt",  2, act_cnt[2], 4);
        chk("np4_pass", 2, {act_pass[2], act_fail[2]}, 2'b10);

        // Mismatch against golden=0, then identical re-run.
        wait_done(BIG, 1100);
        chk("mm_sig",  BIG, act_sig[BIG], exp_full);
        chk("mm_cnt",  BIG, act_cnt[BIG], 1024);
        chk("mm_fail", BIG, act_fail[BIG], exp_full != 16'h0);
        repeat (3) @(negedge clk);
        chk("mm_hold", BIG, act_done[BIG], 1);
        golden[BIG] = exp_full;
        pulse_start(BIG);
        chk("rerun_busy", BIG, act_busy[BIG], 1);
        wait_done(BIG, 1100);
        chk("rerun_sig",  BIG, act_sig[BIG], exp_full);
        chk("rerun_pass", BIG, {act_pass[BIG], act_fail[BIG]}, 2'b10);

        // Abort at pattern 500, then a clean full run.
        pulse_start(BIG);
        wait_cnt(BIG, 500, 600);
        #2 rst = 1'b1;
        #1;
        chk("abort_pattern", BIG, act_pat[BIG], 21'h000001);
        chk("abort_sig",     BIG, act_sig[BIG], 16'h0000);
        chk("abort_cnt",     BIG, act_cnt[BIG], 0);
        chk("abort_flags",   BIG, {act_busy[BIG], act_done[BIG], act_pass[BIG], act_fail[BIG]}, 4'b0000);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        pulse_start(BIG);
        wait_done(BIG, 1100);
        chk("post_abort_sig", BIG, act_sig[BIG], exp_full);

        // start mid-run is ignored.
        pulse_start(BIG);
        wait_cnt(BIG, 10, 20);
        pulse_start(BIG);
        chk("mid_start_cnt", BIG, act_cnt[BIG], 11);
        wait_done(BIG, 1100);
        chk("mid_start_end", BIG, act_cnt[BIG], 1024);
        chk("mid_start_sig", BIG, act_sig[BIG], exp_full);

        // start held high: RUN, RUN, DONE repeating for the 2-pattern harness.
        start[1] = 1'b1;
        for (int n = 1; n <= 9; n++) begin
            @(negedge clk);
            chk("b2b_done", 1, act_done[1], (n % 3) == 0);
        end
        start[1] = 1'b0;

        // Randomized: responses, goldens (sometimes matching), starts, occasional reset.
        for (int c = 0; c < 600; c++) begin
            for (int g = 0; g < ND; g++) begin
                resp_in[g] = 10'($urandom);
                golden[g]  = ($urandom_range(0, 2) == 0) ? misr(m_sig[g], resp_in[g]) : 16'($urandom);
                start[g]   = ($urandom_range(0, 3) == 0);
            end
            golden[BIG] = ($urandom_range(0, 1) == 0) ? exp_full : 16'($urandom);
            rst = (rst == 1'b0) && ($urandom_range(0, 149) == 0);
            @(negedge clk);
        end
        rst   = 1'b0;
        start = '0;
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/ccg_bist_harness.md
Name: ccg_bist_harness

Overview:
- Sequential self-test harness for the combinational CCG benchmark netlists (21 inputs x0..x20, 10 outputs f1..f10).
- Sits at the other end of the netlist's port interface: it generates the x-vector stimulus with an LFSR and compacts the returned f-vector into a MISR signature.
- Compares the final signature against a golden value, so a synthesized or resynthesized netlist can be checked in silicon or in simulation without a reference model.

Parameters:
- IN_W, 21, stimulus width (drives x0..x20; bit i = xi).
- OUT_W, 10, response width (bit i-1 = fi).
- SIG_W, 16, MISR width; OUT_W <= SIG_W required.
- NUM_PATTERNS, 1024, patterns applied per run; legal range 1..2^20.
- SEED, 21'h000001, LFSR seed; a zero value is replaced by 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  begin a run; sampled in IDLE or DONE, ignored in RUN.
- golden  in  SIG_W  expected signature; sampled on the DONE-entry edge.
- response_in  in  OUT_W  netlist outputs f1..f10 (combinational from pattern_out).
- pattern_out  out  IN_W  registered stimulus to x0..x20.
- busy  out  1  high while in RUN.
- done  out  1  high while in DONE.
- pass  out  1  valid in DONE; signature == golden.
- fail  out  1  valid in DONE; signature != golden.
- signature  out  SIG_W  current MISR contents.
- pat_count  out  21  patterns absorbed in the current or last run.

Behaviour:
- Reset (async): state=IDLE, pattern_out=SEED, signature=0, pat_count=0; busy, done, pass and fail all 0.
- FSM states: IDLE, RUN, DONE.
- IDLE --start--> RUN. On that edge: pattern_out=SEED, signature=0, pat_count=0.
- DONE --start--> RUN, with the same reload as from IDLE. done, pass and fail drop on that edge.
- RUN, every edge:
  - signature absorbs response_in. response_in reflects the pattern_out held during the preceding cycle; the netlist is pure combinational, so there is no extra latency stage.
  - LFSR advances.
  - pat_count increments.
- RUN exit: on the edge where pat_count reaches NUM_PATTERNS, go to DONE. That edge performs the NUM_PATTERNS-th absorb. golden is compared against the post-absorb signature; pass and fail are registered on the same edge.
- Exactly NUM_PATTERNS patterns are absorbed. NUM_PATTERNS=1 means RUN lasts one cycle.
- LFSR: Fibonacci, polynomial x^21+x^19+1.
  - fb = p[20]^p[18]; next = {p[19:0], fb}.
  - Period 2^21-1; never reaches zero.
- MISR: polynomial x^16+x^12+x^5+1.
  - fb = s[15]^s[11]^s[4].
  - next = {s[14:0], fb} ^ zero_extend(response_in).
- DONE: pattern_out, signature and pat_count hold. Exactly one of pass/fail is high. done stays high until start or rst.
- start in RUN: ignored; the run is not restarted.
- start held high continuously: back-to-back runs with a single DONE cycle between them.
- rst mid-run: immediate return to reset values; no partial verdict is reported.
- All outputs are registered; there is no combinational path from an input to an output.

Decomposition:
- Package ccg_bist_pkg holds:
  - state enum {IDLE, RUN, DONE};
  - LFSR tap constants (20, 18);
  - MISR polynomial constant 16'h1021;
  - default SEED.
- Natural sub-module: ccg_misr (SIG_W, OUT_W). Ports: clk, rst, clear, enable, data_in, sig.
- LFSR and FSM stay in the top level.

Test Plan:
- Reset value and start: rst, then start with SEED=1 -> during RUN, pattern_out is 0x000001, 0x000002, 0x000004 … 0x040000, then 0x080001, then 0x100002. busy is 1 throughout RUN.
- Zero response: response_in=0, NUM_PATTERNS=4, golden=0 -> DONE after 4 RUN cycles, signature=0, pat_count=4, pass=1, fail=0.
- Constant response: response_in=10'h001.
  - NUM_PATTERNS=1 -> signature=0x0001.
  - NUM_PATTERNS=2 -> signature=0x0003.
  - In both cases golden=0x0003 gives pass only for the 2-pattern run.
- Mismatch: run against a real CCG netlist with golden=0 -> fail=1, pass=0, done held. A second start re-runs the test and produces an identical signature.
- Abort: assert rst at pattern 500 of 1024 -> all outputs return to reset values immediately. A new start runs the full 1024 patterns and yields the same signature as an uninterrupted run.
- start during RUN: pulse start at pattern 10 -> no restart, pat_count continues, DONE is reached at the NUM_PATTERNS boundary.
